// File: rtl/caster_pkg.sv
// -----------------------------------------------------------------------------
// caster_pkg
//   Shared types for the caster bus controller and its arbiter.
//   Holds the default row geometry (16-bit data, 4 casters), the tag and
//   beat types for that geometry, and the controller state encoding.
// -----------------------------------------------------------------------------
package caster_pkg;

   localparam int CASTER_DATA_WIDTH = 16;
   localparam int CASTER_NUM_COL    = 4;
   localparam int CASTER_TW         = $clog2(CASTER_NUM_COL);

   typedef logic [CASTER_TW-1:0] tag_t;

   typedef struct packed {
      tag_t                         tag;
      logic [CASTER_DATA_WIDTH-1:0] data;
   } beat_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } bus_state_e;

endpackage

// File: rtl/caster_rr_arb.sv
// -----------------------------------------------------------------------------
// caster_rr_arb
//   Purely combinational round-robin arbiter. Searches req starting at index
//   ptr, wrapping at N-1 -> 0, and returns the first set request.
//
//   Ports:
//     req      in   N    request vector
//     ptr      in   IW   search start index (highest priority)
//     gnt_vld  out  1    at least one request is set
//     gnt_idx  out  IW   index of the granted request (0 when none)
// -----------------------------------------------------------------------------
module caster_rr_arb #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          gnt_vld,
   output logic [IW-1:0] gnt_idx
);

   always_comb begin
      int unsigned idx;
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment; a path that leaves one unassigned infers a latch.
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/caster_bus_ctrl.sv
// -----------------------------------------------------------------------------
// caster_bus_ctrl
//   Bus-side master for a row of NUM_COL PE casters. Each cycle it selects at
//   most one caster over the shared TAG/EN bus, broadcasting one held write
//   beat to it and/or capturing its result beat into the downstream stream.
//
//   Optional build macro CASTER_BUS_PERF_EN adds wr_beats / rd_beats counters.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     go, stop, busy           run control (IDLE -> RUN -> DRAIN -> IDLE)
//     s_valid/s_ready/s_tag/s_data   upstream write stream
//     caster_ready, caster_valid     per-column caster handshake
//     bus_en, bus_tag, bus_wdata     shared bus broadcast
//     bus_rdata                      OR of all casters' return data
//     m_valid/m_ready/m_tag/m_data   downstream result stream
//     wr_beats, rd_beats             (CASTER_BUS_PERF_EN only) fire counters
// -----------------------------------------------------------------------------
module caster_bus_ctrl
   import caster_pkg::*;
#(
   parameter int DATA_WIDTH = CASTER_DATA_WIDTH,
   parameter int NUM_COL    = CASTER_NUM_COL,
   parameter int TW         = $clog2(NUM_COL)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   input  logic                  stop,
   output logic                  busy,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [TW-1:0]         s_tag,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic [NUM_COL-1:0]    caster_ready,
   input  logic [NUM_COL-1:0]    caster_valid,
   output logic                  bus_en,
   output logic [TW-1:0]         bus_tag,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [TW-1:0]         m_tag,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef CASTER_BUS_PERF_EN
   ,
   output logic [31:0]           wr_beats,
   output logic [31:0]           rd_beats
`endif
);

   bus_state_e            state, state_nxt;

   logic                  wr_vld;
   logic [TW-1:0]         wr_tag;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_vld;
   logic [TW-1:0]         rr_ptr;

   logic [NUM_COL-1:0]    elig;
   logic                  gnt_vld;
   logic [TW-1:0]         gnt_idx;
   logic                  wr_fire;
   logic                  rd_fire;
   logic                  rd_space;
   logic                  s_accept;

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      else     state <= state_nxt;
   end

   // go only acts in IDLE and stop only in RUN, so a simultaneous go/stop in
   // RUN naturally resolves to DRAIN.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (go)                 state_nxt = RUN;
         RUN:     if (stop)               state_nxt = DRAIN;
         DRAIN:   if (!wr_vld && !rd_vld) state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // ---------------------------------------------------------------------------
   // Eligibility and arbitration
   // ---------------------------------------------------------------------------
   // Eligibility needs state != IDLE, which also covers the caster's ID-latch
   // cycle after reset: go cannot take effect before the first edge.
   assign rd_space = ~rd_vld | m_ready;

   always_comb begin
      elig = '0;
      for (int t = 0; t < NUM_COL; t++) begin
         elig[t] = busy
                 & (caster_ready[t] | caster_valid[t])
                 & (~caster_ready[t] | (wr_vld & (wr_tag == TW'(t))))
                 & (~caster_valid[t] | rd_space);
      end
   end

   caster_rr_arb #(
      .N  (NUM_COL),
      .IW (TW)
   ) u_arb (
      .req     (elig),
      .ptr     (rr_ptr),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   assign wr_fire   = gnt_vld & caster_ready[gnt_idx];
   assign rd_fire   = gnt_vld & caster_valid[gnt_idx];

   assign bus_en    = gnt_vld;
   assign bus_tag   = gnt_vld ? gnt_idx : '0;
   assign bus_wdata = wr_fire ? wr_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (gnt_vld)
         rr_ptr <= (gnt_idx == TW'(NUM_COL - 1)) ? '0 : gnt_idx + TW'(1);
   end

   // ---------------------------------------------------------------------------
   // Write holding register: the held beat may leave in the same cycle a new
   // one is accepted, so acceptance takes priority over the clear.
   // ---------------------------------------------------------------------------
   assign s_ready  = (state == RUN) & (~wr_vld | wr_fire);
   assign s_accept = s_valid & s_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_vld  <= 1'b0;
         wr_tag  <= '0;
         wr_data <= '0;
      end else if (s_accept) begin
         wr_vld  <= 1'b1;
         wr_tag  <= s_tag;
         wr_data <= s_data;
      end else if (wr_fire) begin
         wr_vld  <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Result register: a new read reloads it even while the old beat is being
   // consumed, keeping m_valid high across back-to-back results.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld <= 1'b0;
         m_tag  <= '0;
         m_data <= '0;
      end else if (rd_fire) begin
         rd_vld <= 1'b1;
         m_tag  <= gnt_idx;
         m_data <= bus_rdata;
      end else if (m_ready) begin
         rd_vld <= 1'b0;
      end
   end

   assign m_valid = rd_vld;

`ifdef CASTER_BUS_PERF_EN
   // Counters restart on an accepted go so each run reports its own totals.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_beats <= '0;
         rd_beats <= '0;
      end else if (go && state == IDLE) begin
         wr_beats <= '0;
         rd_beats <= '0;
      end else begin
         if (wr_fire) wr_beats <= wr_beats + 32'd1;
         if (rd_fire) rd_beats <= rd_beats + 32'd1;
      end
   end
`endif

endmodule

// File: doc/caster_bus_ctrl.md
Name: caster_bus_ctrl

Overview:
- Bus-side master for a row of NUM_COL PE casters.
- Each cycle it selects one caster by driving the shared TAG/EN bus. It broadcasts one write beat from an upstream stream, and captures that caster's result beat into a downstream stream.
- Sits between the accelerator's data mover and the PE row. It is the other end of the caster TAG/EN/READY/VALID protocol.

Parameters:
- DATA_WIDTH, 16, width of bus write and read data.
- NUM_COL, 4, number of casters on the bus. Tag width TW = $clog2(NUM_COL).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  pulse: IDLE->RUN.
- stop  in  1  pulse: RUN->DRAIN.
- busy  out  1  state != IDLE.
- s_valid  in  1  upstream write beat valid.
- s_ready  out  1  upstream write beat accepted.
- s_tag  in  TW  destination column.
- s_data  in  DATA_WIDTH  write payload.
- caster_ready  in  NUM_COL  per-column CASTER_READY.
- caster_valid  in  NUM_COL  per-column CASTER_VALID.
- bus_en  out  1  CASTER_EN broadcast.
- bus_tag  out  TW  TAG broadcast.
- bus_wdata  out  DATA_WIDTH  data_B2C broadcast.
- bus_rdata  in  DATA_WIDTH  OR of all casters' data_C2B; non-selected casters drive 0.
- m_valid  out  1  result beat valid.
- m_ready  in  1  downstream accepts result.
- m_tag  out  TW  source column of the result.
- m_data  out  DATA_WIDTH  result payload.

Behaviour:
- Reset: state=IDLE; wr_vld=0; rd_vld=0; rr_ptr=0. Every output is 0 at reset, including s_ready, bus_*, m_* and busy.
- FSM IDLE/RUN/DRAIN:
  - IDLE->RUN on go.
  - RUN->DRAIN on stop. If go and stop are asserted in the same cycle, stop wins.
  - DRAIN->IDLE when wr_vld=0 and rd_vld=0.
  - go is ignored outside IDLE. stop is ignored outside RUN.
- Write holding register (1 entry): s_ready = (state==RUN) & (~wr_vld | wr_fire). A registered write beat may leave in the same cycle a new beat is accepted.
- rd_space = ~rd_vld | m_ready.
- Column t is eligible only when all of the following hold:
  - state != IDLE;
  - ready_t | valid_t;
  - ready_t implies (wr_vld & wr_tag==t);
  - valid_t implies rd_space.
  - Purpose: EN is never given to a ready PE with no payload, and a result is never pulled without space to hold it.
- Arbitration is round-robin from rr_ptr over eligible columns.
  - Grant g drives bus_en=1 and bus_tag=g combinationally in the same cycle.
  - bus_wdata = wr_data when the grant is a write, else 0.
  - No eligible column: bus_en=0, bus_tag=0, bus_wdata=0.
  - After each grant, rr_ptr becomes g+1, wrapping NUM_COL-1 -> 0.
- wr_fire = grant & ready_g; clears wr_vld at the next edge.
- rd_fire = grant & valid_g; {m_tag,m_data} <= {g,bus_rdata} at the next edge and rd_vld is set. Read latency is 1 cycle from the grant to m_valid.
- A column that is both ready and valid performs its write and its read in one grant.
- If m_ready and rd_fire occur in the same cycle, the register is reloaded and m_valid stays 1.
- Downstream back-pressure: with rd_vld=1 and m_ready=0, valid-only columns are not granted. Write-only grants continue.
- The caster latches its ID one cycle after reset. No grant occurs in the first cycle after rst deasserts.
- rst mid-transfer discards the held write and result beats immediately.

Optional Feature:
- Macro CASTER_BUS_PERF_EN.
- Defined: adds output ports wr_beats[31:0] and rd_beats[31:0]. These count wr_fire and rd_fire, wrap at 2^32, clear on rst and on go.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package caster_pkg:
  - typedef tag_t = logic[TW-1:0];
  - struct beat_t {tag_t tag; logic[DATA_WIDTH-1:0] data;};
  - enum bus_state_e {IDLE,RUN,DRAIN}.
- Sub-module caster_rr_arb (parameter N): inputs req[N] and ptr; outputs gnt_vld and gnt_idx. Purely combinational.

Test Plan:
1. rst, go, s_beat {tag=2,data=16'hA5A5}, caster_ready=4'b0100 -> bus_en=1, bus_tag=2, bus_wdata=16'hA5A5 for exactly 1 cycle; s_ready=1 again that same cycle.
2. caster_valid=4'b1000, bus_rdata=16'h1234, m_ready=1 -> grant tag 3; m_valid=1 next cycle with m_tag=3 and m_data=16'h1234.
3. caster_valid=4'b1111 held, m_ready=1 throughout -> grants cycle through tags 0,1,2,3,0; m_valid stays 1 continuously.
4. m_ready=0 with a result already held, caster_valid=4'b0010 -> bus_en=0, m_data stable. Raising m_ready -> tag 1 granted that cycle.
5. caster_ready=4'b0001 with no write beat pending -> bus_en never asserted. Then s_tag=0 is accepted and granted the cycle after acceptance.
6. stop while a result is pending -> s_ready=0 and busy=1 until the result is drained. Asserting rst mid-DRAIN clears all outputs to 0 immediately.
